ifetch_buffer: RTL and testbench

- Instruction-fetch front end for the RV32I pipeline.
- Issues word fetches to instruction memory and buffers returned words with their PCs in a small FIFO.
- Presents the buffered words to the decode stage through a valid/ready handshake.
- Supports a single-cycle redirect (branch/jump/trap) that flushes all buffered and in-flight fetches. This decouples decode stalls from memory issue.

---
 rtl/ifetch_buffer_if.sv | 31 +++
 rtl/ifetch_buffer.sv | 117 +++++++++++
 tb/tb_ifetch_buffer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_buffer_if
// Description : Memory, redirect and decode-side signals of the fetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface ifetch_buffer_if;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_READY;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        FD_VALID;
    logic        FD_READY;
    logic [31:0] FD_PC;
    logic [31:0] FD_PC4;
    logic [31:0] FD_IR;

    // master: the fetch buffer itself; slave: memory, redirect source and decode
    modport master (
        output IMEM_REQ, IMEM_ADDR, FD_VALID, FD_PC, FD_PC4, FD_IR,
        input  IMEM_READY, IMEM_RVALID, IMEM_RDATA, REDIRECT, REDIRECT_PC, FD_READY
    );
    modport slave (
        input  IMEM_REQ, IMEM_ADDR, FD_VALID, FD_PC, FD_PC4, FD_IR,
        output IMEM_READY, IMEM_RVALID, IMEM_RDATA, REDIRECT, REDIRECT_PC, FD_READY
    );
endinterface
`default_nettype wire

// File: rtl/ifetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_buffer
// Description : RV32I fetch front end - issues word fetches, buffers returned
//               words with their PCs and hands them to decode; flushes on redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_buffer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter bit          BYTE_SWAP = 1'b1
) (
    input  wire logic       CLK,
    input  wire logic       RST,
    ifetch_buffer_if.master bus
);
    localparam int                c_aw   = $clog2(DEPTH);
    localparam int                c_cw   = c_aw + 1;
    localparam logic [c_cw:0]     c_lim  = (c_cw + 1)'(DEPTH);
    localparam logic [c_cw-1:0]   c_full = c_cw'(DEPTH);
    localparam logic [31:0]       c_rst_pc = {RESET_PC[31:2], 2'b00};

    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_infl_pc;
    logic            r_inflight;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_cw-1:0] r_count;
    logic [31:0]     r_pc_mem [DEPTH];
    logic [31:0]     r_ir_mem [DEPTH];

    logic            w_fd_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_req;
    logic            w_accept;
    logic [c_cw:0]   w_occ;
    logic [31:0]     w_head_pc;
    logic [31:0]     w_head_ir;
    logic [31:0]     w_ir_fmt;
    logic            w_unused_ok;

    assign w_fd_valid = (r_count != '0);
    assign w_pop      = w_fd_valid & bus.FD_READY;
    assign w_push     = bus.IMEM_RVALID & r_inflight & ~bus.REDIRECT;

    // Occupancy counts the outstanding response so a full FIFO can never be overrun.
    assign w_occ    = {1'b0, r_count} + {{c_cw{1'b0}}, r_inflight} - {{c_cw{1'b0}}, w_pop};
    assign w_req    = ~RST & ~bus.REDIRECT & (w_occ < c_lim);
    assign w_accept = w_req & bus.IMEM_READY;

    assign w_unused_ok = ^bus.REDIRECT_PC[1:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fetch_pc <= c_rst_pc;
            r_infl_pc  <= '0;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_accept;
            if (w_accept) begin
                r_infl_pc <= r_fetch_pc;
            end
            if (bus.REDIRECT) begin
                r_fetch_pc <= {bus.REDIRECT_PC[31:2], 2'b00};
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_aw'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_aw'(1);
                end
                r_count <= r_count + {{(c_cw-1){1'b0}}, w_push} - {{(c_cw-1){1'b0}}, w_pop};
            end
        end
    end

    // Storage needs no reset: entries are only observed while counted as valid.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr] <= r_infl_pc;
            r_ir_mem[r_wr_ptr] <= bus.IMEM_RDATA;
        end
    end

    assign w_head_pc = r_pc_mem[r_rd_ptr];
    assign w_head_ir = r_ir_mem[r_rd_ptr];

    generate
        if (BYTE_SWAP) begin : g_swap
            assign w_ir_fmt = {w_head_ir[7:0], w_head_ir[15:8], w_head_ir[23:16], w_head_ir[31:24]};
        end else begin : g_pass
            assign w_ir_fmt = w_head_ir;
        end
    endgenerate

    assign bus.IMEM_REQ  = w_req;
    assign bus.IMEM_ADDR = r_fetch_pc;
    assign bus.FD_VALID  = w_fd_valid;
    assign bus.FD_PC     = w_fd_valid ? w_head_pc : 32'd0;
    assign bus.FD_PC4    = w_fd_valid ? (w_head_pc + 32'd4) : 32'd0;
    assign bus.FD_IR     = w_fd_valid ? w_ir_fmt : 32'd0;

    a_no_overflow : assert property (@(posedge CLK) disable iff (RST)
        !(w_push && !w_pop && (r_count == c_full)));

endmodule
`default_nettype wire

// File: tb/tb_ifetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_buffer
// Description : Self-checking bench: scripted vectors, corner sequences and a
//               randomized run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_buffer;
    localparam logic [31:0] P_RESET_PC  = 32'h0000_0000;
    localparam int          P_DEPTH     = 2;
    localparam bit          P_BYTE_SWAP = 1'b1;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    ifetch_buffer_if bus ();

    ifetch_buffer #(
        .RESET_PC  (P_RESET_PC),
        .DEPTH     (P_DEPTH),
        .BYTE_SWAP (P_BYTE_SWAP)
    ) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    logic        s_valid, s_req;
    logic [31:0] s_pc, s_pc4, s_ir, s_addr;
    bit          stray_next = 1'b0;

    typedef struct {
        logic        rdy;
        logic        fdr;
        logic        redir;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic        ereq;
        logic [31:0] eaddr;
    } vec_t;
    vec_t vq[$];

    // Memory image: every word is distinct over the tested address range.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[26:2], 7'h13};
    endfunction

    function automatic logic [31:0] exp_ir(input logic [31:0] pc);
        logic [31:0] w;
        w = mem_word(pc);
        return P_BYTE_SWAP ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
    endfunction

    task automatic add(input logic rdy, input logic fdr, input logic redir, input logic [31:0] rpc,
                       input logic ev, input logic [31:0] epc, input logic ereq, input logic [31:0] eaddr);
        vec_t v;
        v.rdy = rdy; v.fdr = fdr; v.redir = redir; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.ereq = ereq; v.eaddr = eaddr;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_fd(input string tag, input logic ev, input logic [31:0] epc,
                          input logic ereq, input logic [31:0] eaddr);
        chk({tag, ".valid"}, {31'd0, s_valid}, {31'd0, ev});
        chk({tag, ".pc"},    s_pc,  ev ? epc : 32'd0);
        chk({tag, ".pc4"},   s_pc4, ev ? (epc + 32'd4) : 32'd0);
        chk({tag, ".ir"},    s_ir,  ev ? exp_ir(epc) : 32'd0);
        chk({tag, ".req"},   {31'd0, s_req}, {31'd0, ereq});
        chk({tag, ".addr"},  s_addr, eaddr);
    endtask

    // One cycle: sample outputs mid-cycle, then answer an accepted fetch one cycle later.
    task automatic tick();
        logic acc;
        @(negedge CLK);
        s_valid = bus.FD_VALID;
        s_pc    = bus.FD_PC;
        s_pc4   = bus.FD_PC4;
        s_ir    = bus.FD_IR;
        s_req   = bus.IMEM_REQ;
        s_addr  = bus.IMEM_ADDR;
        @(posedge CLK);
        acc = s_req & bus.IMEM_READY;
        #1;
        bus.IMEM_RVALID = acc | stray_next;
        bus.IMEM_RDATA  = acc ? mem_word(s_addr) : $urandom;
        stray_next      = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q[$];
        logic        m_infl;
        logic [31:0] m_infl_pc, m_fetch, old_fetch;
        logic        cur_rv, ev, pop, ereq, acc, push, redir, rdy;
        logic [31:0] epc, rpc;

        bus.IMEM_READY  = 1'b0;
        bus.IMEM_RVALID = 1'b0;
        bus.IMEM_RDATA  = 32'd0;
        bus.REDIRECT    = 1'b0;
        bus.REDIRECT_PC = 32'd0;
        bus.FD_READY    = 1'b0;

        // rdy fdr redir rpc | valid pc req addr  (row 0 = first cycle after reset release)
        add(1, 0, 0, 0,             0, 0,       1, 32'h000);
        add(1, 0, 0, 0,             0, 0,       1, 32'h004);
        add(1, 0, 0, 0,             1, 32'h000, 0, 32'h008);
        add(1, 0, 0, 0,             1, 32'h000, 0, 32'h008);
        add(1, 0, 0, 0,             1, 32'h000, 0, 32'h008);
        add(1, 1, 0, 0,             1, 32'h000, 1, 32'h008);
        add(1, 1, 0, 0,             1, 32'h004, 1, 32'h00C);
        add(1, 1, 0, 0,             1, 32'h008, 1, 32'h010);
        add(1, 1, 0, 0,             1, 32'h00C, 1, 32'h014);
        add(1, 0, 1, 32'h0000_0102, 1, 32'h010, 0, 32'h018);
        add(1, 1, 0, 0,             0, 0,       1, 32'h100);
        add(1, 1, 0, 0,             0, 0,       1, 32'h104);
        add(1, 1, 0, 0,             1, 32'h100, 1, 32'h108);
        add(1, 1, 0, 0,             1, 32'h104, 1, 32'h10C);
        add(0, 1, 0, 0,             1, 32'h108, 1, 32'h110);
        add(0, 1, 0, 0,             1, 32'h10C, 1, 32'h110);
        add(0, 1, 0, 0,             0, 0,       1, 32'h110);
        add(1, 1, 0, 0,             0, 0,       1, 32'h110);
        add(1, 1, 0, 0,             0, 0,       1, 32'h114);
        add(1, 1, 0, 0,             1, 32'h110, 1, 32'h118);

        #2;
        s_valid = bus.FD_VALID; s_pc = bus.FD_PC; s_pc4 = bus.FD_PC4;
        s_ir = bus.FD_IR; s_req = bus.IMEM_REQ; s_addr = bus.IMEM_ADDR;
        chk_fd("reset", 1'b0, 32'd0, 1'b0, P_RESET_PC);

        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        foreach (vq[i]) begin
            bus.IMEM_READY  = vq[i].rdy;
            bus.FD_READY    = vq[i].fdr;
            bus.REDIRECT    = vq[i].redir;
            bus.REDIRECT_PC = vq[i].rpc;
            tick();
            chk_fd($sformatf("vec%0d", i), vq[i].ev, vq[i].epc, vq[i].ereq, vq[i].eaddr);
        end

        // Back-to-back redirects, the last one to the top of the address space.
        bus.IMEM_READY  = 1'b1;
        bus.FD_READY    = 1'b1;
        bus.REDIRECT    = 1'b1;
        bus.REDIRECT_PC = 32'h0000_0200;
        tick();
        chk("redir_a.req", {31'd0, s_req}, 32'd0);
        bus.REDIRECT_PC = 32'hFFFF_FFFE;
        tick();
        chk("redir_b.req", {31'd0, s_req}, 32'd0);
        bus.REDIRECT = 1'b0;
        tick(); chk_fd("wrap1", 1'b0, 32'd0,         1'b1, 32'hFFFF_FFFC);
        tick(); chk_fd("wrap2", 1'b0, 32'd0,         1'b1, 32'h0000_0000);
        tick(); chk_fd("wrap3", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0004);
        tick(); chk_fd("wrap4", 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0008);

        // Reset while a fetch is outstanding, then a stray response after release.
        RST = 1'b1;
        #1;
        chk("rst_async.valid", {31'd0, bus.FD_VALID}, 32'd0);
        chk("rst_async.req",   {31'd0, bus.IMEM_REQ}, 32'd0);
        chk("rst_async.addr",  bus.IMEM_ADDR, P_RESET_PC);
        tick(); chk_fd("rst_hold", 1'b0, 32'd0, 1'b0, P_RESET_PC);
        tick();
        RST = 1'b0;
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = 32'hDEAD_BEEF;
        tick(); chk_fd("rst_c0", 1'b0, 32'd0,      1'b1, P_RESET_PC);
        tick(); chk_fd("rst_c1", 1'b0, 32'd0,      1'b1, P_RESET_PC + 32'd4);
        tick(); chk_fd("rst_c2", 1'b1, P_RESET_PC, 1'b1, P_RESET_PC + 32'd8);

        // Randomized run against the queue model, from a fresh reset.
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        bus.IMEM_RVALID = 1'b0;
        q.delete();
        m_infl    = 1'b0;
        m_infl_pc = 32'd0;
        m_fetch   = {P_RESET_PC[31:2], 2'b00};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 24) == 0);
            rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            bus.IMEM_READY  = rdy;
            bus.FD_READY    = ($urandom_range(0, 2) != 0);
            bus.REDIRECT    = redir;
            bus.REDIRECT_PC = rpc;
            stray_next      = ($urandom_range(0, 7) == 0);

            cur_rv = bus.IMEM_RVALID;
            ev     = (q.size() != 0);
            epc    = ev ? q[0] : 32'd0;
            pop    = ev & bus.FD_READY;
            ereq   = !redir && ((q.size() + int'(m_infl) - int'(pop)) < P_DEPTH);

            tick();
            chk_fd($sformatf("rnd%0d", cyc), ev, epc, ereq, m_fetch);

            acc       = ereq & rdy;
            push      = cur_rv & m_infl & ~redir;
            old_fetch = m_fetch;
            if (redir) begin
                q.delete();
                m_fetch = {rpc[31:2], 2'b00};
            end else begin
                if (pop)  void'(q.pop_front());
                if (push) q.push_back(m_infl_pc);
                if (acc)  m_fetch = m_fetch + 32'd4;
            end
            m_infl = acc;
            if (acc) m_infl_pc = old_fetch;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
